// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock parametrised FIFO for same-domain buffering. Supports any
//   depth >= 2 (power of two not required), first-word-fall-through or
//   registered read, programmable almost-full / almost-empty thresholds, an
//   occupancy count, a synchronous flush and sticky overflow/underflow flags.
//
// Ports
//   clk           in   single clock, all state on rising edge
//   rst           in   asynchronous active-high reset
//   push          in   write request
//   FIFO_in       in   write data, captured on an accepted push
//   pop           in   read request
//   flush         in   synchronous clear of contents and error flags
//   FIFO_out      out  read data (combinational head if FWFT=1, registered if 0)
//   full          out  count == FIFO_DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  occupancy, 0..FIFO_DEPTH
//   overflow      out  sticky: push seen while full
//   underflow     out  sticky: pop seen while empty
// ----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FWFT       = 1,
    parameter int unsigned AF_LEVEL   = 3,
    parameter int unsigned AE_LEVEL   = 1,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] FIFO_in,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] FIFO_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LastPtr = PTR_W'(FIFO_DEPTH - 1);

    // Parameter legality checks at elaboration time
    if (DATA_WIDTH < 1) begin : g_err_dw
        $error("sync_fifo_param: DATA_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 2) begin : g_err_depth
        $error("sync_fifo_param: FIFO_DEPTH must be >= 2");
    end
    if (FWFT > 1) begin : g_err_fwft
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_err_af
        $error("sync_fifo_param: AF_LEVEL must be in 1..FIFO_DEPTH");
    end
    if (AE_LEVEL > FIFO_DEPTH - 1) begin : g_err_ae
        $error("sync_fifo_param: AE_LEVEL must be in 0..FIFO_DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  push_ok;
    logic                  pop_ok;

    // Flags come from registered count only, so push/pop never reach them
    // combinationally.
    assign full         = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses the pre-edge full/empty: a full FIFO can still pop and
    // an empty FIFO can still push in the same cycle. Flush masks both.
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && full) begin
                overflow_q <= 1'b1;
            end
            if (pop && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= FIFO_in;
        end
    end

    if (FWFT == 1) begin : g_fwft
        // Head is presented directly; zero while empty.
        assign FIFO_out = empty ? '0 : mem[rd_ptr_q];
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] dout_q;

        // Loads only on an accepted pop; holds otherwise, even once empty.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else if (flush) begin
                dout_q <= '0;
            end else if (pop_ok) begin
                dout_q <= mem[rd_ptr_q];
            end
        end

        assign FIFO_out = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned AF    = 3;
    localparam int unsigned AE    = 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] out1, out0;
    logic          full1, empty1, af1, ae1, ovf1, udf1;
    logic          full0, empty0, af0, ae0, ovf0, udf0;
    logic [CW-1:0] cnt1, cnt0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) u_fwft (
        .clk(clk), .rst(rst), .push(push), .FIFO_in(din), .pop(pop), .flush(flush),
        .FIFO_out(out1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1)
    );

    sync_fifo_param #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) u_reg (
        .clk(clk), .rst(rst), .push(push), .FIFO_in(din), .pop(pop), .flush(flush),
        .FIFO_out(out0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0)
    );

    // Reference model: contents as a plain queue plus sticky bits and the
    // last word handed out by a registered read.
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_udf;
    logic [DW-1:0] m_dout0;

    // Scoreboards of popped words, one per read style
    logic [DW-1:0] exp1[$];
    logic [DW-1:0] exp0[$];

    int nvec  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;
    bit pend0 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus. Called just after a rising edge; model
    // acceptance is decided from pre-edge state, committed after the edge.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit po, input bit fl);
        logic [DW-1:0] nq[$];
        bit            nov, nud;
        logic [DW-1:0] nd0;
        bit            was_full, was_empty;
        push  = p;
        din   = d;
        pop   = po;
        flush = fl;
        nq  = mq;
        nov = m_ovf;
        nud = m_udf;
        nd0 = m_dout0;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (fl) begin
            nq.delete();
            nov = 1'b0;
            nud = 1'b0;
            nd0 = '0;
        end else begin
            if (po && !was_empty) begin
                nd0 = nq.pop_front();
                exp1.push_back(nd0);
                exp0.push_back(nd0);
            end
            if (p && !was_full) nq.push_back(d);
            if (p && was_full) nov = 1'b1;
            if (po && was_empty) nud = 1'b1;
        end
        @(posedge clk);
        #1;
        mq      = nq;
        m_ovf   = nov;
        m_udf   = nud;
        m_dout0 = nd0;
    endtask

    task automatic model_reset();
        mq.delete();
        exp1.delete();
        exp0.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_dout0 = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cnt1"}, 32'(cnt1), 0);
        chk({tag, "_cnt0"}, 32'(cnt0), 0);
        chk({tag, "_empty"}, {30'b0, empty1, empty0}, 32'h3);
        chk({tag, "_full"}, {30'b0, full1, full0}, 0);
        chk({tag, "_ae"}, {30'b0, ae1, ae0}, 32'h3);
        chk({tag, "_af"}, {30'b0, af1, af0}, 0);
        chk({tag, "_flags"}, {28'b0, ovf1, ovf0, udf1, udf0}, 0);
        chk({tag, "_out1"}, 32'(out1), 0);
        chk({tag, "_out0"}, 32'(out0), 0);
    endtask

    // Per-cycle status check against the model
    always @(negedge clk) begin : status_check
        int n;
        if (chk_en && !rst) begin
            n = mq.size();
            chk("count1", 32'(cnt1), n);
            chk("count0", 32'(cnt0), n);
            chk("full", {30'b0, full1, full0}, (n == DEPTH) ? 3 : 0);
            chk("empty", {30'b0, empty1, empty0}, (n == 0) ? 3 : 0);
            chk("almost_full", {30'b0, af1, af0}, (n >= AF) ? 3 : 0);
            chk("almost_empty", {30'b0, ae1, ae0}, (n <= AE) ? 3 : 0);
            chk("overflow", {30'b0, ovf1, ovf0}, m_ovf ? 3 : 0);
            chk("underflow", {30'b0, udf1, udf0}, m_udf ? 3 : 0);
            chk("head_fwft", 32'(out1), (n != 0) ? 32'(mq[0]) : 0);
            chk("dout_reg", 32'(out0), 32'(m_dout0));
        end
    end

    // Scoreboard monitor: FWFT word is on the bus during the accepted pop
    // cycle; registered word appears in the cycle after the pop edge.
    always @(negedge clk) begin : sb_monitor
        logic [DW-1:0] e;
        if (rst) begin
            pend0 = 1'b0;
        end else begin
            if (pend0) begin
                if (exp0.size() == 0) begin
                    chk("sb0_underrun", 1, 0);
                end else begin
                    e = exp0.pop_front();
                    chk("sb0_data", 32'(out0), 32'(e));
                end
            end
            pend0 = pop && !flush && !empty0;
            if (pop && !flush && !empty1) begin
                if (exp1.size() == 0) begin
                    chk("sb1_underrun", 1, 0);
                end else begin
                    e = exp1.pop_front();
                    chk("sb1_data", 32'(out1), 32'(e));
                end
            end
        end
    end

    initial begin
        model_reset();
        #1;
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Fill to full then drain in order
        for (int i = 0; i < 5; i++) step(1, 8'hA0 + 8'(i), 0, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
        step(0, 0, 0, 0);

        // Pointer wrap: 4 rounds of push3/pop3
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) step(1, 8'h30 + 8'(r * 3 + i), 0, 0);
            for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        end
        step(0, 0, 0, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 5; i++) step(1, 8'hB0 + 8'(i), 0, 0);
        step(1, 8'hEE, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        // Underflow, then empty with simultaneous push and pop
        step(0, 0, 1, 0);
        step(1, 8'h11, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Overflow to sticky, drop to 3, then flush with push asserted
        for (int i = 0; i < 6; i++) step(1, 8'hC0 + 8'(i), 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 8'h77, 1, 1);
        step(0, 0, 0, 0);

        // Randomised traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3);
        end

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) step(1, 8'hD0 + 8'(i), i == 2, 0);
        push = 1'b1;
        pop  = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        push = 1'b0;
        pop  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_vals("rst_held");
        rst = 1'b0;
        step(1, 8'h5A, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        chk("sb1_drained", exp1.size(), 0);
        chk("sb0_drained", exp0.size(), 0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
